// File: rtl/video_timing_m.sv
// Raster timing generator: dot/line counters, active-low syncs, repeated-pixel coordinates.
// Latency: every output is registered from next-state counters, so it lines up with hcount/vcount of the same cycle.
// Backpressure: none; counters free-run every gpu_clk with no stall or enable.
// Optional vblank interrupt (vblank_irq / vblank_ack ports) is built only when VIDEO_TIMING_VBLANK_IRQ_EN is defined.
module video_timing_m #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 31,
  parameter int LINE_REPEAT = 2     // dots/lines per logical pixel: 2 or 4
) (
  input  logic       gpu_clk,
  input  logic       rst,           // asynchronous, active-low
  output logic [8:0] current_x,
  output logic [8:0] current_y,
  output logic [8:0] next_x,
  output logic [8:0] next_y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  ,
  output logic       vblank_irq,
  input  logic       vblank_ack
`endif
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int LR_SHIFT = (LINE_REPEAT == 4) ? 2 : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Last logical line: a trailing half-used logical line (odd V_TOTAL) still counts.
  localparam logic [8:0] Y_LAST   = 9'((V_TOTAL + LINE_REPEAT - 1) / LINE_REPEAT - 1);
  localparam logic [8:0] RST_NY   = (Y_LAST == 9'd0) ? 9'd0 : 9'd1;

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic [9:0] h_after;

  logic [8:0] cx_nxt;
  logic [8:0] cy_nxt;
  logic [8:0] nx_nxt;
  logic [8:0] ny_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       vis_nxt;
  logic       fs_nxt;

  // Dot/line counter to logical pixel coordinate, truncated to 9 bits.
  function automatic logic [8:0] to_logical(input logic [9:0] cnt);
    logic [9:0] scaled;
    scaled = cnt >> LR_SHIFT;
    return scaled[8:0];
  endfunction

  // Next counter values: hcount wraps at end of line, vcount steps on that wrap.
  always_comb begin
    h_nxt = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
    v_nxt = vcount;
    if (hcount == H_LAST) begin
      v_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end
    h_after = (h_nxt == H_LAST) ? 10'd0 : h_nxt + 10'd1;
  end

  // Output values for the coming cycle, derived from the next counter values.
  always_comb begin
    cx_nxt  = to_logical(h_nxt);
    cy_nxt  = to_logical(v_nxt);
    nx_nxt  = to_logical(h_after);
    ny_nxt  = (cy_nxt == Y_LAST) ? 9'd0 : cy_nxt + 9'd1;
    hs_nxt  = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
    vs_nxt  = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
    vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    fs_nxt  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  // Free-running dot and line counters.
  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else begin
      hcount <= h_nxt;
      vcount <= v_nxt;
    end
  end

  // Registered timing outputs; reset shows the origin dot, syncs idle, no frame pulse.
  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      current_x   <= 9'd0;
      current_y   <= 9'd0;
      next_x      <= 9'd0;
      next_y      <= RST_NY;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      visible     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      current_x   <= cx_nxt;
      current_y   <= cy_nxt;
      next_x      <= nx_nxt;
      next_y      <= ny_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      visible     <= vis_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  logic irq_set;
  logic in_set_cycle;

  // Set edge lands on hcount=0 of the first blanked line; an ack seen on that
  // edge or during that set cycle is ignored so a late ack cannot eat a new frame's interrupt.
  assign irq_set      = (h_nxt == 10'd0) && (v_nxt == V_VIS);
  assign in_set_cycle = (hcount == 10'd0) && (vcount == V_VIS);

  // Sticky vblank interrupt level, cleared one edge after an ack.
  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      vblank_irq <= 1'b0;
    end else if (irq_set) begin
      vblank_irq <= 1'b1;
    end else if (vblank_ack && !in_set_cycle) begin
      vblank_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_m.sv
// Directed bench for video_timing_m: full-width lines (800 dots), short 15-line frames.
// Positions are tracked by the bench itself; outputs sampled on the falling edge.
// Vblank interrupt checks are compiled in with VIDEO_TIMING_VBLANK_IRQ_EN.
module tb_video_timing_m;

  localparam int HT = 800;
  localparam int VT = 15;
  localparam int FR = HT * VT;

  logic       gpu_clk = 1'b0;
  logic       rst;
  logic [8:0] current_x, current_y, next_x, next_y;
  logic       hsync, vsync, visible, frame_start;
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  logic       vblank_irq;
  logic       vblank_ack;
`endif

  int total = 0;
  int bad   = 0;
  int hp    = 0;
  int vp    = 0;

  video_timing_m #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(8),   .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3),
    .LINE_REPEAT(2)
  ) dut (
    .gpu_clk     (gpu_clk),
    .rst         (rst),
    .current_x   (current_x),
    .current_y   (current_y),
    .next_x      (next_x),
    .next_y      (next_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .visible     (visible),
    .frame_start (frame_start)
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    ,
    .vblank_irq  (vblank_irq),
    .vblank_ack  (vblank_ack)
`endif
  );

  always #5 gpu_clk = ~gpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, tracking the expected counter position, then sit on the falling edge.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge gpu_clk);
      hp++;
      if (hp == HT) begin
        hp = 0;
        vp = (vp == VT - 1) ? 0 : vp + 1;
      end
    end
    if (n > 0) @(negedge gpu_clk);
  endtask

  task automatic goto_pos(input int h, input int v);
    adv(((v * HT + h) - (vp * HT + hp) + FR) % FR);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cx"}, current_x, 0);
    chk({tag, "_cy"}, current_y, 0);
    chk({tag, "_nx"}, next_x, 0);
    chk({tag, "_ny"}, next_y, 1);
    chk({tag, "_hs"}, hsync, 1);
    chk({tag, "_vs"}, vsync, 1);
    chk({tag, "_vis"}, visible, 1);
    chk({tag, "_fs"}, frame_start, 0);
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    chk({tag, "_irq"}, vblank_irq, 0);
`endif
  endtask

  initial begin
    int falls, vlow, fs_cnt;
    logic prev_hs;

    rst = 1'b0;
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    vblank_ack = 1'b0;
`endif
    // Reset held for 10 cycles
    repeat (10) begin
      @(negedge gpu_clk);
      chk_reset_vals("rst_hold");
    end
    rst = 1'b1;
    hp = 0;
    vp = 0;

    // First edge after release: hcount=1
    adv(1);
    chk("first_cx", current_x, 0);
    chk("first_nx", next_x, 1);
    chk("first_fs", frame_start, 0);
    chk("first_vis", visible, 1);

    // One line, vcount=0
    goto_pos(3, 0);   chk("cx_h3", current_x, 1);
    goto_pos(639, 0); chk("vis_h639", visible, 1); chk("cx_h639", current_x, 319);
    goto_pos(640, 0); chk("vis_h640", visible, 0);
    goto_pos(655, 0); chk("hs_h655", hsync, 1);
    goto_pos(656, 0); chk("hs_h656", hsync, 0);
    goto_pos(751, 0); chk("hs_h751", hsync, 0);
    goto_pos(752, 0); chk("hs_h752", hsync, 1);
    goto_pos(798, 0); chk("cx_h798", current_x, 399); chk("nx_h798", next_x, 399);
    goto_pos(799, 0); chk("cx_h799", current_x, 399); chk("nx_h799", next_x, 0);
    goto_pos(0, 1);   chk("cy_v1", current_y, 0); chk("ny_v1", next_y, 1); chk("nx_v1", next_x, 0);
    goto_pos(0, 2);   chk("cy_v2", current_y, 1); chk("ny_v2", next_y, 2);

    // End of visible region and vblank interrupt set
    goto_pos(639, 7); chk("vis_v7_h639", visible, 1);
    goto_pos(640, 7); chk("vis_v7_h640", visible, 0);
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    goto_pos(799, 7); chk("irq_before_set", vblank_irq, 0);
`endif
    goto_pos(0, 8);   chk("vis_v8", visible, 0);
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    chk("irq_set", vblank_irq, 1);
`endif
    goto_pos(0, 9);   chk("cy_v9", current_y, 4); chk("ny_v9", next_y, 5);

    // vsync window: lines 10 and 11
    goto_pos(799, 9);  chk("vs_v9_end", vsync, 1);
    goto_pos(0, 10);   chk("vs_v10", vsync, 0);
    goto_pos(799, 11); chk("vs_v11_end", vsync, 0);
    goto_pos(0, 12);   chk("vs_v12", vsync, 1);

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    // Ack during vblank clears one edge later; ack while low does nothing
    chk("irq_held", vblank_irq, 1);
    vblank_ack = 1'b1;
    adv(1);
    chk("irq_acked", vblank_irq, 0);
    adv(1);
    vblank_ack = 1'b0;
    chk("irq_ack_low", vblank_irq, 0);
`endif

    // Logical y wrap on an odd line count
    goto_pos(0, 13);   chk("cy_v13", current_y, 6); chk("ny_v13", next_y, 7);
    goto_pos(0, 14);   chk("cy_v14", current_y, 7); chk("ny_v14", next_y, 0);
    goto_pos(799, 14); chk("nx_v14_end", next_x, 0); chk("fs_before", frame_start, 0);
    goto_pos(0, 0);    chk("fs_origin", frame_start, 1); chk("cy_v0", current_y, 0); chk("ny_v0", next_y, 1);
    adv(1);            chk("fs_one_cycle", frame_start, 0);

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
    // Ack held across the set edge and the set cycle: set wins
    goto_pos(799, 7);
    vblank_ack = 1'b1;
    adv(1);
    chk("irq_setwin_a", vblank_irq, 1);
    adv(1);
    vblank_ack = 1'b0;
    chk("irq_setwin_b", vblank_irq, 1);
    adv(1);
    chk("irq_setwin_c", vblank_irq, 1);
    vblank_ack = 1'b1;
    adv(1);
    vblank_ack = 1'b0;
    chk("irq_clear2", vblank_irq, 0);
`endif

    // One full frame window: 15 hsync pulses, 1600 vsync-low cycles, one frame_start at origin
    goto_pos(3, 8);
    falls = 0; vlow = 0; fs_cnt = 0;
    prev_hs = hsync;
    for (int i = 0; i < FR; i++) begin
      adv(1);
      if (prev_hs && !hsync) falls++;
      if (!vsync) vlow++;
      if (frame_start) begin
        fs_cnt++;
        chk("fs_pos", vp * HT + hp, 0);
      end
      prev_hs = hsync;
    end
    chk("frame_hs_pulses", falls, 15);
    chk("frame_vs_low", vlow, 1600);
    chk("frame_fs_count", fs_cnt, 1);

    // Asynchronous reset mid-frame during hsync, vsync and vblank
    goto_pos(700, 11);
    chk("pre_rst_hs", hsync, 0);
    chk("pre_rst_vs", vsync, 0);
    chk("pre_rst_cx", current_x, 350);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    repeat (3) begin
      @(negedge gpu_clk);
      chk_reset_vals("rst_mid");
    end
    rst = 1'b1;
    hp = 0;
    vp = 0;
    adv(1);
    chk("resume_cx", current_x, 0);
    chk("resume_nx", next_x, 1);
    chk("resume_vs", vsync, 1);
    goto_pos(656, 0); chk("resume_hs", hsync, 0);
    goto_pos(0, 1);   chk("resume_cy", current_y, 0); chk("resume_ny", next_y, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
